legv8_multicycle_control: RTL and testbench

//  Multi-cycle main control FSM for the LEGv8 datapath; producer of the 2-bit ALUOp consumed by ALUControl.

---
 rtl/legv8_pkg.sv | 63 ++++++
 rtl/legv8_opcode_decoder.sv | 31 +++
 rtl/legv8_multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_legv8_multicycle_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Purpose : shared encodings for the LEGv8 multi-cycle control path (opcodes, ALUOp, mux selects, states).
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: widths OPC_W/ALUOP_W/STATE_W, opcode match values, ALUOp codes, alu_src_b/pc_src selects,
//           state encodings, and the decoder's classification struct.
package legv8_pkg;

  localparam int OPC_W   = 11;  // IR[31:21]
  localparam int ALUOP_W = 2;   // toward ALUControl
  localparam int STATE_W = 4;   // state_o width

  // Full 11-bit opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  // Short-format opcodes: CBZ matches on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0]       OP_CBZ  = 8'b10110100;
  localparam logic [5:0]       OP_B    = 6'b000101;

  // ALUOp toward ALUControl
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_BR     = 2'b10;

  // State encoding
  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd3;
  localparam logic [STATE_W-1:0] S_WB_R     = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd6;
  localparam logic [STATE_W-1:0] S_WB_LD    = 4'd7;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd8;
  localparam logic [STATE_W-1:0] S_BR_CBZ   = 4'd9;
  localparam logic [STATE_W-1:0] S_BR_UNC   = 4'd10;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd11;

  // Opcode classification; exactly one bit is set for any opcode
  typedef struct packed {
    logic is_r;
    logic is_ld;
    logic is_st;
    logic is_cbz;
    logic is_b;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/legv8_opcode_decoder.sv
// Purpose : classify the 11-bit IR opcode into R-type / load / store / CBZ / B / illegal.
// Latency : combinational, zero cycles.
// Backpressure: none; output follows i_opcode continuously.
// Ports   : i_opcode (OPC_W) in, o_dec (dec_t one-hot class) out.
module legv8_opcode_decoder
  import legv8_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  // Exact 11-bit matches are tried first; only if none hits do the
  // shorter CBZ/B prefix patterns get a chance.
  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: o_dec.is_r  = 1'b1;
      OP_LDUR:                        o_dec.is_ld = 1'b1;
      OP_STUR:                        o_dec.is_st = 1'b1;
      default: begin
        if (i_opcode[10:3] == OP_CBZ)
          o_dec.is_cbz = 1'b1;
        else if (i_opcode[10:5] == OP_B)
          o_dec.is_b = 1'b1;
        else
          o_dec.is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Purpose : LEGv8 multi-cycle main control FSM; sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
// Latency : R 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles with mem_ready=1; each memory wait cycle adds 1.
// Backpressure: FETCH/MEM_RD/MEM_WR hold their request until mem_ready; mem_ready is ignored in all other states.
// Build option: ILLEGAL_TRAP_EN adds output illegal_op and a sticky TRAP state for unknown opcodes;
//               without it unknown opcodes retire as NOPs from DECODE.
// Ports   : clk, rst_n (async active-low), opcode (IR[31:21]), zero, mem_ready in;
//           ir_write, pc_write, pc_src, alu_op, alu_src_b, reg2_loc, reg_write, mem_to_reg,
//           mem_read, mem_write, instr_done, state_o [, illegal_op] out.
module legv8_multicycle_control
  import legv8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_b,
  output logic               reg2_loc,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               mem_read,
  output logic               mem_write,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  dec_t               w_dec;

  legv8_opcode_decoder u_dec (
    .i_opcode (opcode),
    .o_dec    (w_dec)
  );

  assign state_o = r_state;

  // State register: async reset lands in IDLE, which decodes to all-zero outputs,
  // so any in-flight memory request is withdrawn the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     w_next_state = S_FETCH;
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_dec.is_r)
          w_next_state = S_EXEC_R;
        else if (w_dec.is_ld || w_dec.is_st)
          w_next_state = S_MEM_ADDR;
        else if (w_dec.is_cbz)
          w_next_state = S_BR_CBZ;
        else if (w_dec.is_b)
          w_next_state = S_BR_UNC;
        else if (w_dec.is_illegal)
`ifdef ILLEGAL_TRAP_EN
          w_next_state = S_TRAP;
`else
          w_next_state = S_FETCH;
`endif
        else
          w_next_state = S_FETCH;
      end
      S_EXEC_R:   w_next_state = S_WB_R;
      S_WB_R:     w_next_state = S_FETCH;
      // IR is held stable after FETCH, so the live decode still names the access kind here.
      S_MEM_ADDR: w_next_state = w_dec.is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = mem_ready ? S_WB_LD : S_MEM_RD;
      S_WB_LD:    w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_BR_CBZ:   w_next_state = S_FETCH;
      S_BR_UNC:   w_next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next_state = S_TRAP;  // sticky until reset
`endif
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output decode: Moore from state, except the mem_ready-qualified FETCH strobes,
  // the MEM_WR completion pulse, the zero-qualified CBZ PC write and the NOP retire in DECODE.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_PLUS4;
    alu_op     = ALUOP_ADD;
    alu_src_b  = SRCB_REG;
    reg2_loc   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_src    = PCSRC_PLUS4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is classified.
        alu_src_b = SRCB_IMM_SL2;
        alu_op    = ALUOP_ADD;
`ifndef ILLEGAL_TRAP_EN
        instr_done = w_dec.is_illegal;
`endif
      end
      S_EXEC_R: begin
        alu_op    = ALUOP_RTYPE;
        alu_src_b = SRCB_REG;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_op    = ALUOP_ADD;
        alu_src_b = SRCB_IMM;
        reg2_loc  = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_BR_CBZ: begin
        alu_op     = ALUOP_PASSB;
        alu_src_b  = SRCB_REG;
        reg2_loc   = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_BR_UNC: begin
        pc_src     = PCSRC_BR;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Purpose : directed scoreboard bench for legv8_multicycle_control.
// Latency : stimulus pushes the expected per-cycle output vector; monitor compares at the falling edge.
// Backpressure: mem_ready is driven per cycle from the directed sequences.
module tb_legv8_multicycle_control;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, reg2_loc, reg_write, mem_to_reg, mem_read, mem_write, instr_done;
  logic [1:0]  pc_src, alu_op, alu_src_b;
  logic [3:0]  state_o;
  logic        w_ill;

  legv8_multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .reg2_loc   (reg2_loc),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .instr_done (instr_done),
    .state_o    (state_o)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_op (w_ill)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign w_ill = 1'b0;
`endif

  always #5 clk = ~clk;

  // {state, ir_write, pc_write, pc_src, alu_op, alu_src_b, reg2_loc, reg_write, mem_to_reg, mem_read, mem_write, instr_done, illegal}
  typedef logic [18:0] vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010111111;
  localparam logic [10:0] BAD  = 11'b11111111111;

  function automatic vec_t ex(input logic [3:0] st, input logic irw, input logic pcw,
                              input logic [1:0] pcs, input logic [1:0] aop, input logic [1:0] asb,
                              input logic r2, input logic rw, input logic m2r, input logic mr,
                              input logic mw, input logic dn, input logic il);
    return {st, irw, pcw, pcs, aop, asb, r2, rw, m2r, mr, mw, dn, il};
  endfunction

  vec_t v_idle, f_rdy, f_wait, v_dec, v_exec, v_wbr, v_addr, v_rd, v_wbld, v_wr_wait, v_wr_done, v_unc;

  vec_t obs;
  assign obs = {state_o, ir_write, pc_write, pc_src, alu_op, alu_src_b, reg2_loc, reg_write,
                mem_to_reg, mem_read, mem_write, instr_done, w_ill};

  // Monitor: one comparison per pushed cycle, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    vec_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", n, obs, e);
      end
    end
  end

  task automatic step(input logic [10:0] opc, input logic rdy, input logic z, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    opcode = opc; mem_ready = rdy; zero = z;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  task automatic step_rst(input logic rst, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n = rst; mem_ready = 1'b0;
    exp_q.push_back(e); name_q.push_back(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [10:0] rops [3];
    rops[0] = SUB; rops[1] = ANDI; rops[2] = ORR;

    v_idle    = ex(S_IDLE,     0,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0);
    f_rdy     = ex(S_FETCH,    1,1,2'b00,2'b00,2'b01, 0,0,0,1,0,0,0);
    f_wait    = ex(S_FETCH,    0,0,2'b00,2'b00,2'b01, 0,0,0,1,0,0,0);
    v_dec     = ex(S_DECODE,   0,0,2'b00,2'b00,2'b11, 0,0,0,0,0,0,0);
    v_exec    = ex(S_EXEC_R,   0,0,2'b00,2'b10,2'b00, 0,0,0,0,0,0,0);
    v_wbr     = ex(S_WB_R,     0,0,2'b00,2'b00,2'b00, 0,1,0,0,0,1,0);
    v_addr    = ex(S_MEM_ADDR, 0,0,2'b00,2'b00,2'b10, 1,0,0,0,0,0,0);
    v_rd      = ex(S_MEM_RD,   0,0,2'b00,2'b00,2'b00, 0,0,0,1,0,0,0);
    v_wbld    = ex(S_WB_LD,    0,0,2'b00,2'b00,2'b00, 0,1,1,0,0,1,0);
    v_wr_wait = ex(S_MEM_WR,   0,0,2'b00,2'b00,2'b00, 0,0,0,0,1,0,0);
    v_wr_done = ex(S_MEM_WR,   0,0,2'b00,2'b00,2'b00, 0,0,0,0,1,1,0);
    v_unc     = ex(S_BR_UNC,   0,1,2'b10,2'b00,2'b00, 0,0,0,0,0,1,0);

    // Reset state, then IDLE for one cycle after release
    step_rst(1'b0, v_idle, "reset_low0");
    step_rst(1'b0, v_idle, "reset_low1");
    step_rst(1'b1, v_idle, "idle_after_release");

    // ADD: FETCH, DECODE, EXEC_R, WB_R
    step(ADD, 1, 0, f_rdy,  "add_fetch");
    step(ADD, 1, 0, v_dec,  "add_decode");
    step(ADD, 1, 0, v_exec, "add_exec");
    step(ADD, 1, 0, v_wbr,  "add_wb");

    // Other R-types, the first one with a fetch wait
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(rops[i], 0, 0, f_wait, "r_fetch_wait");
      step(rops[i], 1, 0, f_rdy,  "r_fetch");
      step(rops[i], 0, 0, v_dec,  "r_decode");
      step(rops[i], 0, 0, v_exec, "r_exec");
      step(rops[i], 0, 0, v_wbr,  "r_wb");
    end

    // LDUR with three memory wait cycles in MEM_RD (8 cycles total)
    step(LDUR, 1, 0, f_rdy,  "ld_fetch");
    step(LDUR, 1, 0, v_dec,  "ld_decode");
    step(LDUR, 1, 0, v_addr, "ld_addr");
    step(LDUR, 0, 0, v_rd,   "ld_rd_wait0");
    step(LDUR, 0, 0, v_rd,   "ld_rd_wait1");
    step(LDUR, 0, 0, v_rd,   "ld_rd_wait2");
    step(LDUR, 1, 0, v_rd,   "ld_rd_done");
    step(LDUR, 0, 0, v_wbld, "ld_wb");

    // CBZ taken (mem_ready low in BR_CBZ is ignored)
    step(CBZ, 1, 1, f_rdy, "cbz1_fetch");
    step(CBZ, 0, 1, v_dec, "cbz1_decode");
    step(CBZ, 0, 1, ex(S_BR_CBZ, 0,1,2'b01,2'b01,2'b00, 1,0,0,0,0,1,0), "cbz1_branch");
    // CBZ not taken
    step(CBZ, 1, 0, f_rdy, "cbz0_fetch");
    step(CBZ, 1, 0, v_dec, "cbz0_decode");
    step(CBZ, 1, 0, ex(S_BR_CBZ, 0,0,2'b01,2'b01,2'b00, 1,0,0,0,0,1,0), "cbz0_branch");

    // STUR then B back-to-back
    step(STUR, 1, 0, f_rdy,     "st_fetch");
    step(STUR, 1, 0, v_dec,     "st_decode");
    step(STUR, 1, 0, v_addr,    "st_addr");
    step(STUR, 1, 0, v_wr_done, "st_wr_done");
    step(BR,   1, 0, f_rdy,     "b_fetch");
    step(BR,   1, 0, v_dec,     "b_decode");
    step(BR,   1, 0, v_unc,     "b_branch");

    // STUR with reset asserted mid-cycle during the MEM_WR wait
    step(STUR, 1, 0, f_rdy,     "st2_fetch");
    step(STUR, 1, 0, v_dec,     "st2_decode");
    step(STUR, 0, 0, v_addr,    "st2_addr");
    step(STUR, 0, 0, v_wr_wait, "st2_wr_wait");
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(v_idle); name_q.push_back("st2_async_reset");
    step_rst(1'b0, v_idle, "st2_reset_hold");
    step_rst(1'b1, v_idle, "st2_release");
    step(BR, 1, 0, f_rdy, "post_rst_fetch");
    step(BR, 1, 0, v_dec, "post_rst_decode");
    step(BR, 1, 0, v_unc, "post_rst_branch");

    // Unknown opcode
    step(BAD, 1, 0, f_rdy, "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(BAD, 1, 0, v_dec, "bad_decode");
    for (int i = 0; i < 3; i++)
      step(ADD, 1, 0, ex(S_TRAP, 0,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,1), "trap_sticky");
    step_rst(1'b0, v_idle, "trap_reset");
    step_rst(1'b1, v_idle, "trap_release");
    step(ADD, 1, 0, f_rdy, "trap_refetch");
`else
    step(BAD, 1, 0, ex(S_DECODE, 0,0,2'b00,2'b00,2'b11, 0,0,0,0,0,1,0), "nop_decode");
    step(ADD, 1, 0, f_rdy,  "nop_next_fetch");
    step(ADD, 1, 0, v_dec,  "nop_next_decode");
    step(ADD, 1, 0, v_exec, "nop_next_exec");
`endif

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
